// File: rtl/mode_digit_counter.sv
// mode_digit_counter: registered multi-digit counter built from 4-bit digits.
// Each digit counts 0-9 (mode=0) or 0-F (mode=1); mode may change any cycle.
// Ripple carry across all digits resolves combinationally within one cycle.
// Status outputs: tc (comb), in_range (comb), wrap (1-cycle pulse), ovf (sticky).
module mode_digit_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  in_range,
  output logic                  ovf
);

  logic [3:0]          digit_max;
  logic [3:0]          digit;
  logic                carry;
  logic                all_max;
  logic [4*DIGITS-1:0] count_inc;

  // Per-digit step and ripple carry; a digit at or above max (including
  // illegal BCD codes A-F in decimal mode) returns to 0 and carries out.
  always_comb begin
    digit_max = mode ? 4'hF : 4'h9;
    count_inc = count;
    digit     = '0;
    carry     = 1'b1;
    in_range  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      digit = count[4*i +: 4];
      if (digit > digit_max) begin
        in_range = 1'b0;
      end
      if (carry) begin
        count_inc[4*i +: 4] = (digit >= digit_max) ? 4'h0 : digit + 4'h1;
      end
      carry = carry & (digit >= digit_max);
    end
    all_max = carry;
    tc      = en & all_max;
  end

  // Counter and status registers; priority clr > load > en > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      count <= count_inc;
      wrap  <= all_max;
      if (all_max) begin
        ovf <= 1'b1;
      end
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_digit_counter.sv
// Bench for mode_digit_counter: directed stimulus pushes expectations tagged
// with the cycle in which they hold; a negedge monitor pops and compares them.
module tb_mode_digit_counter;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        en;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tc;
  logic        wrap;
  logic        in_range;
  logic        ovf;

  mode_digit_counter #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .in_range (in_range),
    .ovf      (ovf)
  );

  typedef enum int { K_CNT, K_TC, K_WRAP, K_OVF, K_INR } kind_t;

  typedef struct {
    int          cyc;
    string       name;
    kind_t       kind;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cycle    = 0;
  int   compared = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [15:0] act;
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      exp_t e;
      e = q.pop_front();
      case (e.kind)
        K_CNT:   act = count;
        K_TC:    act = {15'd0, tc};
        K_WRAP:  act = {15'd0, wrap};
        K_OVF:   act = {15'd0, ovf};
        default: act = {15'd0, in_range};
      endcase
      compared = compared + 1;
      if (e.cyc != cycle) begin
        mismatched = mismatched + 1;
        $display("FAIL %s: missed check slot (cycle %0d, due %0d)", e.name, cycle, e.cyc);
      end else if (act !== e.val) begin
        mismatched = mismatched + 1;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cycle);
      end
    end
  end

  task automatic expect_now(input string name, input kind_t kind, input logic [15:0] val);
    exp_t e;
    e.cyc  = cycle;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    tick(); tick();
    rst_n = 1'b1;
    expect_now("rst_cnt",  K_CNT,  16'h0000);
    expect_now("rst_wrap", K_WRAP, 16'd0);
    expect_now("rst_ovf",  K_OVF,  16'd0);
    expect_now("rst_tc",   K_TC,   16'd0);
    expect_now("rst_inr",  K_INR,  16'd1);

    // 1. hex roll
    mode = 1'b1; load = 1'b1; load_val = 16'hFFFE;
    tick();
    load = 1'b0; en = 1'b1;
    expect_now("hex_ld",    K_CNT, 16'hFFFE);
    expect_now("hex_tc0",   K_TC,  16'd0);
    tick();
    expect_now("hex_ffff",  K_CNT,  16'hFFFF);
    expect_now("hex_tc1",   K_TC,   16'd1);
    expect_now("hex_wrap0", K_WRAP, 16'd0);
    tick();
    en = 1'b0;
    expect_now("hex_zero",  K_CNT,  16'h0000);
    expect_now("hex_wrap1", K_WRAP, 16'd1);
    expect_now("hex_ovf1",  K_OVF,  16'd1);
    tick();
    expect_now("hex_wrapclr", K_WRAP, 16'd0);
    expect_now("hex_ovfstk",  K_OVF,  16'd1);

    // 2. decimal carry
    mode = 1'b0; load = 1'b1; load_val = 16'h0099;
    tick();
    load = 1'b0; en = 1'b1;
    expect_now("dec_tc0", K_TC, 16'd0);
    tick();
    en = 1'b0;
    expect_now("dec_cnt",  K_CNT,  16'h0100);
    expect_now("dec_wrap", K_WRAP, 16'd0);
    expect_now("dec_ovf",  K_OVF,  16'd1);

    // 3. illegal BCD digit self-corrects
    load = 1'b1; load_val = 16'h000C;
    tick();
    load = 1'b0; en = 1'b1;
    expect_now("bcd_ld",   K_CNT, 16'h000C);
    expect_now("bcd_inr0", K_INR, 16'd0);
    tick();
    en = 1'b0;
    expect_now("bcd_cnt",  K_CNT, 16'h0010);
    expect_now("bcd_inr1", K_INR, 16'd1);

    // 4. priority clr > load > en
    load = 1'b1; load_val = 16'h1234;
    tick();
    clr = 1'b1; load = 1'b1; en = 1'b1;
    expect_now("pri_ld",   K_CNT, 16'h1234);
    expect_now("pri_ovf1", K_OVF, 16'd1);
    tick();
    clr = 1'b0; load = 1'b1; en = 1'b1; load_val = 16'h0042;
    expect_now("pri_clr",  K_CNT, 16'h0000);
    expect_now("pri_ovf0", K_OVF, 16'd0);
    tick();
    load = 1'b0; en = 1'b0;
    expect_now("pri_load", K_CNT, 16'h0042);

    // 5. mode switch
    load = 1'b1; load_val = 16'h0009;
    tick();
    load = 1'b0; mode = 1'b1;
    expect_now("ms_tc_hex", K_TC,  16'd0);
    expect_now("ms_inr",    K_INR, 16'd1);
    tick();
    mode = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    expect_now("ms_dec_inc", K_CNT, 16'h0010);
    load = 1'b1; load_val = 16'h9999;
    tick();
    // load holds 9999 while en shows tc for decimal mode
    load = 1'b1; en = 1'b1; mode = 1'b0;
    expect_now("ms_tc_dec", K_TC, 16'd1);
    tick();
    load = 1'b0; en = 1'b1; mode = 1'b1;
    expect_now("ms_hold9999", K_CNT, 16'h9999);
    expect_now("ms_tc_hex0",  K_TC,  16'd0);
    tick();
    en = 1'b0;
    expect_now("ms_hex_inc", K_CNT,  16'h999A);
    expect_now("ms_wrap0",   K_WRAP, 16'd0);

    // 6. async reset mid-run
    mode = 1'b1; load = 1'b1; load_val = 16'hFFFF;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    load = 1'b1; load_val = 16'h5A59; en = 1'b1;
    expect_now("ar_ovf_set", K_OVF, 16'd1);
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    expect_now("ar_run",  K_CNT, 16'h5A5A);
    expect_now("ar_ovf1", K_OVF, 16'd1);
    tick();
    rst_n = 1'b0;
    expect_now("ar_cnt0",  K_CNT,  16'h0000);
    expect_now("ar_wrap0", K_WRAP, 16'd0);
    expect_now("ar_ovf0",  K_OVF,  16'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1; en = 1'b1;
    tick();
    en = 1'b0;
    expect_now("ar_first", K_CNT, 16'h0001);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      mismatched = mismatched + q.size();
      $display("FAIL drain: %0d expectations never checked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
